// File: rtl/alu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU sequencing controller: ALU op-code values,
// bit positions inside the 4-bit ALU flag vector {V, Z, C, N}, and the
// controller FSM state encoding.
// -----------------------------------------------------------------------------
package alu_ctrl_pkg;

  // ALU operation codes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Positions inside the ALU flag vector
  localparam int FLAG_N = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 3;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage : alu_ctrl_pkg

// File: rtl/alu_ctrl_regfile.sv
// -----------------------------------------------------------------------------
// alu_ctrl_regfile
// NREG x WIDTH general register file for the ALU controller.
// Two combinational read ports, one synchronous write port, all entries
// cleared by the asynchronous active-low reset.
//
// Ports:
//   clk, rst_n            clock / async active-low reset
//   we, waddr, wdata      write port (takes effect on the rising edge)
//   raddr_a -> rdata_a    read port A (combinational)
//   raddr_b -> rdata_b    read port B (combinational)
// -----------------------------------------------------------------------------
module alu_ctrl_regfile #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] regs [NREG];

  // NOTE: the array is built from flops, not a RAM macro, so every entry can
  // be cleared by the async reset; a RAM-inferred array would need this loop
  // removed and an explicit init sequence instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      // NOTE: non-blocking so a same-cycle read sees the pre-edge value,
      // which matches the flop behaviour in simulation and silicon.
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule : alu_ctrl_regfile

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
// Sequencing initiator for an external combinational ALU. Accepts a
// register-transfer command, reads operands from the local register file,
// presents them to the ALU for one cycle, writes the ALU result back and
// returns result + raw ALU flags over a valid/ready response channel.
//
// Optional feature macro: ALU_CTRL_SAT_EN
//   When defined, ADD/SUB results that overflow (flag V set) are replaced by
//   the signed saturation limit chosen by the sign of operand A. Flags are
//   always passed through unmodified.
//
// Ports:
//   clk, rst_n                        clock / async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_op, cmd_dst, cmd_src_a,
//   cmd_src_b, cmd_use_imm, cmd_imm   command fields
//   alu_a, alu_b, alu_op              registered ALU operand/op drive
//   alu_x, alu_flag                   ALU result and flags {V,Z,C,N}
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_flag                written-back value and raw ALU flags
// -----------------------------------------------------------------------------
module alu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_x,
  input  logic [3:0]       alu_flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flag
);

  state_t           state;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] wb_data;
  logic             wb_en;

  // Writeback happens on the edge that leaves EXEC; an async reset during
  // EXEC wipes the state before that edge, so the write never lands.
  assign wb_en = (state == ST_EXEC);

  alu_ctrl_regfile #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .AW    (AW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (wb_en),
    .waddr   (dst_q),
    .wdata   (wb_data),
    .raddr_a (cmd_src_a),
    .rdata_a (rd_a),
    .raddr_b (cmd_src_b),
    .rdata_b (rd_b)
  );

  // Value that is both written back and returned on rsp_data.
  // NOTE: the default assignment first keeps this block free of latches
  // whichever way the macro is set.
  always_comb begin
    wb_data = alu_x;
`ifdef ALU_CTRL_SAT_EN
    if (((alu_op == OP_ADD) || (alu_op == OP_SUB)) && alu_flag[FLAG_V]) begin
      // Overflow direction follows the sign of A: positive A can only
      // overflow upward, negative A only downward.
      wb_data = alu_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Single-process FSM; cmd_ready and rsp_valid are registered so they are
  // glitch-free and, by construction, never high together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      dst_q     <= '0;
      rsp_data  <= '0;
      rsp_flag  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // cmd_ready is 1 throughout IDLE, so cmd_valid alone is the
            // handshake here. Operands are read now; alu_* then hold their
            // values until the next acceptance.
            alu_a     <= rd_a;
            alu_b     <= cmd_use_imm ? cmd_imm : rd_b;
            alu_op    <= cmd_op;
            dst_q     <= cmd_dst;
            cmd_ready <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= wb_data;
          rsp_flag  <= alu_flag;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : alu_ctrl

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl
// Self-checking bench for alu_ctrl. Contains a behavioural model of the
// 8-bit ALU (drives alu_x/alu_flag from the DUT's alu_* outputs) and a
// reference register array that predicts every response.
// Honours ALU_CTRL_SAT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;
  import alu_ctrl_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_dst, cmd_src_a, cmd_src_b;
  logic       cmd_use_imm;
  logic [7:0] cmd_imm;
  logic [7:0] alu_a, alu_b, alu_x;
  logic [2:0] alu_op;
  logic [3:0] alu_flag;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flag;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: the architectural register contents
  logic [7:0] ref_regs [4];

  always #5 clk = ~clk;

  alu_ctrl #(.WIDTH(8), .NREG(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_dst     (cmd_dst),
    .cmd_src_a   (cmd_src_a),
    .cmd_src_b   (cmd_src_b),
    .cmd_use_imm (cmd_use_imm),
    .cmd_imm     (cmd_imm),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_x       (alu_x),
    .alu_flag    (alu_flag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_flag    (rsp_flag)
  );

  // Behavioural ALU, integer arithmetic. Returns {V,Z,C,N, x}.
  // Shifts are by one place and report C = 0; SUB reports C as borrow.
  function automatic logic [11:0] alu_fn(input logic [2:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    int ua, ub, sa, sb, r, s;
    logic [7:0] x;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      OP_ADD: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      OP_SUB: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      OP_AND: r = ua & ub;
      OP_OR:  r = ua | ub;
      OP_XOR: r = ua ^ ub;
      OP_NOT: r = 255 - ua;
      OP_SHL: r = ua * 2;
      default: r = ua / 2;
    endcase
    x = r[7:0];
    return {v, (x == 8'h00), c, x[7], x};
  endfunction

  assign {alu_flag, alu_x} = alu_fn(alu_op, alu_a, alu_b);

  // Reference prediction for one command against ref_regs
  function automatic logic [11:0] predict(input logic [2:0] op, input logic [1:0] sa,
                                          input logic [1:0] sb, input logic ui,
                                          input logic [7:0] imm);
    logic [7:0] a, b, x;
    logic [3:0] f;
    a = ref_regs[sa];
    b = ui ? imm : ref_regs[sb];
    {f, x} = alu_fn(op, a, b);
`ifdef ALU_CTRL_SAT_EN
    if ((op == OP_ADD || op == OP_SUB) && f[3]) x = (a >= 8'h80) ? 8'h80 : 8'h7F;
`endif
    return {f, x};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present a command once cmd_ready is seen; it is accepted on the next edge.
  task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                      input logic [1:0] sb, input logic ui, input logic [7:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb;
    cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for a response, optionally stall, then complete the handshake.
  task automatic get_rsp(input int stall, output logic [7:0] d, output logic [3:0] f);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
    check("ready_valid_excl", {31'd0, cmd_ready}, 32'd0);
    repeat (stall) @(negedge clk);
    d = rsp_data;
    f = rsp_flag;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  // Full command: send, collect, update the reference registers
  task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ui, input logic [7:0] imm,
                         input int stall, output logic [7:0] gd, output logic [3:0] gf,
                         output logic [7:0] md, output logic [3:0] mf);
    {mf, md} = predict(op, sa, sb, ui, imm);
    send(op, dst, sa, sb, ui, imm);
    get_rsp(stall, gd, gf);
    ref_regs[dst] = md;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] dst;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       ui;
    logic [7:0] imm;
    logic [7:0] exp_data;
    logic [3:0] exp_flag;
  } vec_t;

  vec_t vecs [13];

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] gd, md, hold_d;
    logic [3:0] gf, mf, hold_f;
    logic [2:0] last_op;
    logic [7:0] last_a;

    // Directed vectors, expectations worked out by hand from the ALU rules
    vecs[0]  = '{OP_OR,  2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 4'b0100};
    vecs[1]  = '{OP_OR,  2'd1, 2'd1, 2'd0, 1'b1, 8'h00, 8'h00, 4'b0100};
    vecs[2]  = '{OP_OR,  2'd2, 2'd2, 2'd0, 1'b1, 8'h00, 8'h00, 4'b0100};
    vecs[3]  = '{OP_OR,  2'd3, 2'd3, 2'd0, 1'b1, 8'h00, 8'h00, 4'b0100};
    vecs[4]  = '{OP_OR,  2'd1, 2'd0, 2'd0, 1'b1, 8'h5A, 8'h5A, 4'b0000};
    vecs[5]  = '{OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'hA6, 8'h00, 4'b0110};
    vecs[6]  = '{OP_OR,  2'd1, 2'd0, 2'd0, 1'b1, 8'h70, 8'h70, 4'b0000};
`ifdef ALU_CTRL_SAT_EN
    vecs[7]  = '{OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h20, 8'h7F, 4'b1001};
    vecs[8]  = '{OP_OR,  2'd3, 2'd1, 2'd0, 1'b1, 8'h00, 8'h7F, 4'b0000};
`else
    vecs[7]  = '{OP_ADD, 2'd1, 2'd1, 2'd0, 1'b1, 8'h20, 8'h90, 4'b1001};
    vecs[8]  = '{OP_OR,  2'd3, 2'd1, 2'd0, 1'b1, 8'h00, 8'h90, 4'b0001};
`endif
    vecs[9]  = '{OP_OR,  2'd0, 2'd0, 2'd0, 1'b1, 8'h81, 8'h81, 4'b0001};
    vecs[10] = '{OP_SHL, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h02, 4'b0000};
    vecs[11] = '{OP_OR,  2'd2, 2'd3, 2'd0, 1'b1, 8'hFF, 8'hFF, 4'b0001};
    vecs[12] = '{OP_NOT, 2'd2, 2'd2, 2'd1, 1'b0, 8'h00, 8'h00, 4'b0100};

    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
    cmd_use_imm = 1'b0; cmd_imm = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_abop", {13'd0, alu_op, alu_a, alu_b}, 32'd0);
    check("rst_rsp", {20'd0, rsp_flag, rsp_data}, 32'd0);

    // ---- directed table ----
    for (int i = 0; i < 13; i++) begin
      run_cmd(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].ui, vecs[i].imm,
              0, gd, gf, md, mf);
      check($sformatf("vec%0d_data", i), {24'd0, gd}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_flag", i), {28'd0, gf}, {28'd0, vecs[i].exp_flag});
    end
    // NOT drives B even though it ignores it: B came from r1
    check("not_b_driven", {24'd0, alu_b}, {24'd0, ref_regs[1]});

    // ---- backpressure: response held for 5 cycles, stray command ignored ----
    {mf, md} = predict(OP_OR, 2'd0, 2'd0, 1'b1, 8'h30);
    send(OP_OR, 2'd3, 2'd0, 2'd0, 1'b1, 8'h30);
    @(negedge clk);
    check("bp_valid_up", {31'd0, rsp_valid}, 32'd1);
    hold_d = rsp_data;
    hold_f = rsp_flag;
    check("bp_data", {24'd0, hold_d}, {24'd0, md});
    check("bp_flag", {28'd0, hold_f}, {28'd0, mf});
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        cmd_op = OP_OR; cmd_dst = 2'd0; cmd_src_a = 2'd1; cmd_use_imm = 1'b1;
        cmd_imm = 8'hEE; cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("bp_hold%0d", c),
            {18'd0, rsp_valid, cmd_ready, hold_f, hold_d},
            {18'd0, 1'b1, 1'b0, rsp_flag, rsp_data});
    end
    cmd_valid = 1'b0;
    ref_regs[3] = md;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_release", {30'd0, rsp_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});
    // r0 must not have been touched by the ignored pulse
    run_cmd(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h00, 0, gd, gf, md, mf);
    check("bp_r0_intact", {24'd0, gd}, {24'd0, md});

    // ---- reset in EXEC: no writeback, no response ----
    @(negedge clk);
    cmd_op = OP_ADD; cmd_dst = 2'd3; cmd_src_a = 2'd0; cmd_src_b = 2'd0;
    cmd_use_imm = 1'b1; cmd_imm = 8'h11; cmd_valid = 1'b1;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_exec_valid", {30'd0, rsp_valid, cmd_ready}, {30'd0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_exec_quiet%0d", c), {31'd0, rsp_valid}, 32'd0);
    end
    run_cmd(OP_OR, 2'd0, 2'd3, 2'd0, 1'b1, 8'h00, 0, gd, gf, md, mf);
    check("rst_exec_r3", {20'd0, gf, gd}, {20'd0, 4'b0100, 8'h00});

    // ---- random commands against the reference model ----
    last_op = '0;
    last_a  = '0;
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [1:0] dst, sa, sb;
      logic       ui;
      logic [7:0] imm;
      op  = 3'($urandom_range(0, 7));
      dst = 2'($urandom_range(0, 3));
      sa  = 2'($urandom_range(0, 3));
      sb  = 2'($urandom_range(0, 3));
      ui  = 1'($urandom_range(0, 1));
      imm = 8'($urandom_range(0, 255));
      last_op = op;
      last_a  = ref_regs[sa];
      run_cmd(op, dst, sa, sb, ui, imm, int'($urandom_range(0, 2)), gd, gf, md, mf);
      check($sformatf("rnd%0d_data", i), {24'd0, gd}, {24'd0, md});
      check($sformatf("rnd%0d_flag", i), {28'd0, gf}, {28'd0, mf});
    end
    // alu_* keep their last values after the command completes
    repeat (2) @(negedge clk);
    check("alu_hold", {21'd0, alu_op, alu_a}, {21'd0, last_op, last_a});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_ctrl
